// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - cache subsystem sizing constants
package cache_pkg;

   localparam int NUM_MEM_REQ = 2;

endpackage

// File: rtl/interface_pkg.sv
// rtl/interface_pkg.sv - memory request/response structs and arbiter state encoding
package interface_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] address;
      logic        wen;
      logic [31:0] data;
      logic [3:0]  strobe;
   } Memory_Request;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } Memory_Response;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RELEASE
   } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: first set request at or after the pointer
module rr_priority_picker #(
   parameter int N    = 2,
   parameter int ID_W = 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] rr_ptr_i,
   output logic            found_o,
   output logic [ID_W-1:0] idx_o
);

   int cand;

   // Scan from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = (int'(rr_ptr_i) + k) % N;
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one memory port among NUM_REQ cache controllers
module mem_port_arbiter
   import interface_pkg::*;
#(
   parameter int NUM_REQ = cache_pkg::NUM_MEM_REQ,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  Memory_Request     ReqIn   [NUM_REQ],
   output Memory_Response    RespOut [NUM_REQ],
   output Memory_Request     MemReq,
   input  Memory_Response    MemResp,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy
);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   Memory_Request       latch_q, latch_d;
   logic                abort_q, abort_d;
   logic [NUM_REQ-1:0]  req_vec;
   logic                pick_found;
   logic [ID_W-1:0]     pick_idx;
   logic                resp_fire;

   always_comb begin
      req_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_vec[i] = ReqIn[i].valid;
      end
   end

   rr_priority_picker #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_picker (
      .req_i    (req_vec),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (pick_found),
      .idx_o    (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         latch_q  <= '0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         latch_q  <= latch_d;
         abort_q  <= abort_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      latch_d   = latch_q;
      abort_d   = abort_q;
      resp_fire = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               latch_d = ReqIn[pick_idx];
               grant_d = pick_idx;
               abort_d = 1'b0;
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE, ARB_WAIT: begin
            if (MemResp.valid) begin
               // Memory cannot cancel, so an aborted owner still completes silently.
               resp_fire = !abort_q && ReqIn[grant_q].valid;
               rr_ptr_d  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
               state_d   = ARB_RELEASE;
            end else begin
               if (!ReqIn[grant_q].valid) begin
                  abort_d = 1'b1;
               end
               state_d = ARB_WAIT;
            end
         end
         ARB_RELEASE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_comb begin
      busy   = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
      MemReq = '0;
      if (busy) begin
         MemReq       = latch_q;
         MemReq.valid = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         RespOut[i] = '0;
      end
      if (resp_fire) begin
         RespOut[grant_q].valid = 1'b1;
         RespOut[grant_q].data  = MemResp.data;
      end
   end

   assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench with a transaction-level arbiter model
module tb_mem_port_arbiter;
   import interface_pkg::*;

   localparam int N  = 3;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   Memory_Request  req_in   [N];
   Memory_Response resp_out [N];
   Memory_Request  mem_req;
   Memory_Response mem_resp;
   logic [IW-1:0]  grant_id;
   logic           busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NUM_REQ (N),
      .ID_W    (IW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ReqIn    (req_in),
      .RespOut  (resp_out),
      .MemReq   (mem_req),
      .MemResp  (mem_resp),
      .grant_id (grant_id),
      .busy     (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: owner (-1 when the port is free), one cool-down cycle after each
   // completion, and a pointer to the requester with first claim next time.
   int            m_owner = -1;
   int            m_last  = 0;
   int            m_ptr   = 0;
   bit            m_cool  = 1'b0;
   bit            m_abort = 1'b0;
   Memory_Request m_latch = '0;
   bit            m_pulse [N];
   int            pend    [N];

   task automatic model_cycle();
      Memory_Request exp_req;
      logic          exp_v;
      logic [31:0]   exp_d;
      bit            got;
      chk("busy", 128'(busy), 128'(m_owner >= 0));
      chk("grant_id", 128'(grant_id), 128'(m_last));
      exp_req = '0;
      if (m_owner >= 0) begin
         exp_req       = m_latch;
         exp_req.valid = 1'b1;
      end
      chk("mem_req", 128'(mem_req), 128'(exp_req));
      for (int j = 0; j < N; j++) begin
         exp_v = (m_owner == j) && mem_resp.valid && !m_abort && req_in[j].valid;
         exp_d = exp_v ? mem_resp.data : 32'h0;
         chk($sformatf("resp_valid[%0d]", j), 128'(resp_out[j].valid), 128'(exp_v));
         chk($sformatf("resp_data[%0d]", j), 128'(resp_out[j].data), 128'(exp_d));
         m_pulse[j] = exp_v;
      end
      if (rst) begin
         m_owner = -1;
         m_last  = 0;
         m_ptr   = 0;
         m_cool  = 1'b0;
         m_abort = 1'b0;
         m_latch = '0;
      end else if (m_owner >= 0) begin
         if (mem_resp.valid) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cool  = 1'b1;
         end else if (!req_in[m_owner].valid) begin
            m_abort = 1'b1;
         end
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else begin
         got = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!got && req_in[(m_ptr + k) % N].valid) begin
               got     = 1'b1;
               m_owner = (m_ptr + k) % N;
               m_last  = m_owner;
               m_latch = req_in[m_owner];
               m_abort = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) begin
         if (m_pulse[i]) begin
            if ($urandom_range(0, 1) == 1) pend[i] = 1;
            else req_in[i].valid = 1'b0;
         end else if (pend[i] != 0) begin
            pend[i]         = 0;
            req_in[i].valid = 1'b0;
         end else if (!req_in[i].valid) begin
            if ($urandom_range(0, 2) == 0) begin
               req_in[i].valid   = 1'b1;
               req_in[i].address = $urandom;
               req_in[i].wen     = 1'($urandom_range(0, 1));
               req_in[i].data    = $urandom;
               req_in[i].strobe  = 4'($urandom_range(0, 15));
            end
         end else begin
            if ($urandom_range(0, 39) == 0) req_in[i].valid = 1'b0;
            else if ($urandom_range(0, 7) == 0) req_in[i].data = $urandom;
         end
      end
      mem_resp.valid = ($urandom_range(0, 2) == 0);
      mem_resp.data  = $urandom;
      rst            = ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         req_in[i] = '0;
         pend[i]   = 0;
         m_pulse[i] = 1'b0;
      end
      mem_resp = '0;
      @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      tick();

      // Single read from requester 0, memory answers on the third cycle.
      req_in[0].valid   = 1'b1;
      req_in[0].address = 32'h0000_1000;
      tick();
      tick();
      tick();
      mem_resp.valid = 1'b1;
      mem_resp.data  = 32'hDEAD_BEEF;
      tick();
      mem_resp       = '0;
      req_in[0]      = '0;
      tick();
      tick();

      // Write from requester 1; data changes after grant must not reach memory.
      req_in[1].valid   = 1'b1;
      req_in[1].wen     = 1'b1;
      req_in[1].address = 32'h40;
      req_in[1].data    = 32'h1234_5678;
      req_in[1].strobe  = 4'hF;
      tick();
      req_in[1].data = 32'h0;
      tick();
      tick();
      mem_resp.valid = 1'b1;
      mem_resp.data  = 32'h5555_0001;
      tick();
      mem_resp  = '0;
      req_in[1] = '0;
      tick();

      // Stray response while idle.
      mem_resp.valid = 1'b1;
      mem_resp.data  = 32'hAA;
      tick();
      mem_resp = '0;
      tick();

      for (int c = 0; c < 4000; c++) begin
         drive_random();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between NUM_REQ cache controllers, for example an I-cache and a D-cache controller.
- Each requester drives the level-valid Memory_Request protocol: valid is held until Memory_Response.valid is seen.
- The block selects one requester round-robin, latches its request, and forwards it to memory. It then routes the single response pulse back to that requester only.
- Sits between the cache controllers and the memory model/controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the grant index.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ReqIn  input  Memory_Request[NUM_REQ]  per-requester memory requests (valid, address, wen, data, strobe)
- RespOut  output  Memory_Response[NUM_REQ]  per-requester responses (valid, data)
- MemReq  output  Memory_Request  request to the shared memory
- MemResp  input  Memory_Response  response from the shared memory
- grant_id  output  ID_W  index of the current or last owner
- busy  output  1  high while a transaction is outstanding

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0.
  - MemReq all fields 0.
  - RespOut[i].valid=0 for all i; RespOut[i].data=0.
  - Latched request register=0.
- States: IDLE, ISSUE, WAIT_RESP, RELEASE.
- IDLE:
  - If any ReqIn[i].valid is set, select the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch that ReqIn entry, set grant_id to the index, go to ISSUE.
  - Otherwise stay in IDLE.
  - Arbitration takes 1 cycle; no combinational path from ReqIn to MemReq.
- ISSUE:
  - MemReq is driven from the latch with MemReq.valid=1; busy=1.
  - Go to WAIT_RESP next cycle unconditionally.
  - If MemResp.valid is already high in ISSUE, treat it as the response: complete and go to RELEASE.
- WAIT_RESP:
  - MemReq.valid=1 from the latch, held stable; busy=1.
  - On MemResp.valid: RespOut[grant_id].valid=1 and RespOut[grant_id].data=MemResp.data in the same cycle (combinational pass-through, 0 added latency).
  - Set rr_ptr=(grant_id+1) mod NUM_REQ, go to RELEASE.
- RELEASE:
  - Exactly 1 cycle; MemReq.valid=0; busy=0.
  - ReqIn is ignored so the just-served requester's stale valid, which drops one cycle after the response, is not re-granted.
  - Go to IDLE.
- Response routing:
  - RespOut[j].valid=0 for every j≠grant_id at all times.
  - RespOut[*].data=MemResp.data for the granted index, 0 otherwise.
- MemResp.valid in IDLE or RELEASE is a stray response: drop it, no RespOut pulse.
- Granted requester deasserts valid before the response (abort): keep the transaction (memory is not cancellable).
  - Wait for MemResp.valid, suppress the RespOut pulse, then RELEASE.
  - rr_ptr still advances.
- Latched fields (address, wen, data, strobe) are frozen from grant until RELEASE. Requester changes in that window have no effect.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Back-to-back minimum transaction period is 4 cycles (IDLE, ISSUE, WAIT_RESP, RELEASE) with 1-cycle memory response latency.
- Reset mid-transaction:
  - Abandons the transaction; all outputs return to reset values next cycle.
  - A late MemResp after reset is dropped as stray.

Decomposition:
- interface_pkg:
  - Reuse the existing Memory_Request and Memory_Response structs.
  - Add a typedef enum for the arbiter states (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RELEASE).
- cache_pkg: add NUM_MEM_REQ=2 as the system default.
- Sub-module: rr_priority_picker.
  - Combinational: inputs req vector and rr_ptr; outputs found and idx.
  - Reusable for future tag-array port sharing.

Test Plan:
- Single request: requester 0 reads 0x0000_1000; memory responds in cycle +3 with data 0xDEADBEEF → MemReq.valid rises 1 cycle after ReqIn[0].valid. RespOut[0].valid pulses once with 0xDEADBEEF; RespOut[1].valid stays 0.
- Simultaneous: both requesters valid from reset, 1-cycle memory latency → grants 0 then 1. Second MemReq.valid rises 4 cycles after the first; rr_ptr returns to 0.
- Write-through forwarding: requester 1 writes wen=1, addr 0x40, data 0x12345678, strobe 0xF → MemReq carries identical fields. Changing ReqIn[1].data to 0 after grant leaves MemReq.data=0x12345678.
- Stale valid: requester 0 holds valid 1 cycle past its response pulse and requester 1 is idle → no second grant to 0 occurs during RELEASE. After RELEASE a fresh request from 0 is granted.
- Abort and stray: requester 0 drops valid while in WAIT_RESP; memory responds with 0xAA → no RespOut pulse. A MemResp.valid injected in IDLE produces no RespOut pulse.
- Reset mid-op: assert rst while in WAIT_RESP → next cycle MemReq.valid=0, busy=0, grant_id=0. A late MemResp.valid is ignored.
